// File: rtl/risc_v_mike_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_mike_pkg
// Shared types and constants for the risc_v_mike instruction fetch path.
//   t_pc_addr      : byte address type used for the program counter
//   t_fetch_state  : fetch controller states (IDLE, RUN, HALT)
//   t_fetch_entry  : one fetch buffer entry {pc, instr}
//   PC_INC         : sequential PC increment (one 32-bit instruction)
//   is_misaligned  : true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package risc_v_mike_pkg;

    localparam int DATA_32_W = 32;
    localparam int PC_W      = 32;

    typedef logic [PC_W-1:0] t_pc_addr;

    localparam t_pc_addr PC_INC = t_pc_addr'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } t_fetch_state;

    typedef struct packed {
        t_pc_addr              pc;
        logic [DATA_32_W-1:0]  instr;
    } t_fetch_entry;

    function automatic logic is_misaligned(input t_pc_addr addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/risc_v_mike_fetch_fifo.sv
// -----------------------------------------------------------------------------
// risc_v_mike_fetch_fifo
// Small circular buffer holding fetched {pc, instr} entries between the
// fetch controller and decode.
//   DEPTH    : number of entries, power of two and >= 2
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset of pointers and occupancy
//   i_flush  : discard all entries (wins over push and pop)
//   i_push   : write i_wdata at the tail (caller guarantees !full or pop)
//   i_pop    : remove the head (caller guarantees !empty)
//   i_wdata  : entry to write
//   o_rdata  : entry at the head (undefined content when empty)
//   o_full   : all DEPTH entries occupied
//   o_empty  : no entries occupied
// -----------------------------------------------------------------------------
module risc_v_mike_fetch_fifo
    import risc_v_mike_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  t_fetch_entry i_wdata,
    output t_fetch_entry o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage carries data only; occupancy is tracked by pointers and count,
    // so it needs no reset.
    t_fetch_entry     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_push & ~i_flush;
    assign w_rd = i_pop  & ~i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, push and pop share the same slot: the head is read out
    // combinationally before the edge overwrites it.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// -----------------------------------------------------------------------------
// risc_v_mike_fetch_unit
// Instruction fetch: keeps the PC, reads a combinational instruction memory,
// and queues {pc, instr} pairs for decode through a small buffer.
//   RESET_PC       : PC loaded on reset
//   FIFO_DEPTH     : fetch buffer entries (power of two, >= 2)
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   fetch_en       : allows new fetches
//   imem_addr      : byte address to instruction memory (equals PC)
//   imem_rd_data   : instruction word for imem_addr, same cycle
//   redirect_valid : branch/jump redirect request (flushes the buffer)
//   redirect_pc    : redirect target
//   instr_valid    : buffer head is valid
//   instr_data     : head instruction (0 when empty)
//   instr_pc       : head byte address (0 when empty)
//   instr_ready    : decode accepts the head
//   fetch_misalign : sticky misaligned-target flag
// Build option: RISC_V_MIKE_FETCH_MISALIGN_CHK_EN enables misaligned redirect
// detection (HALT state and the fetch_misalign port). Without it the low two
// bits of redirect_pc are ignored.
// -----------------------------------------------------------------------------
module risc_v_mike_fetch_unit
    import risc_v_mike_pkg::*;
#(
    parameter t_pc_addr RESET_PC   = 32'h0,
    parameter int       FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    output t_pc_addr             imem_addr,
    input  logic [DATA_32_W-1:0] imem_rd_data,
    input  logic                 redirect_valid,
    input  t_pc_addr             redirect_pc,
    output logic                 instr_valid,
    output logic [DATA_32_W-1:0] instr_data,
    output t_pc_addr             instr_pc,
    input  logic                 instr_ready
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
    ,
    output logic                 fetch_misalign
`endif
);

    t_fetch_state r_state;
    t_fetch_state w_state_next;
    t_pc_addr     r_pc;
    t_pc_addr     w_redir_pc;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    t_fetch_entry w_wdata;
    t_fetch_entry w_rdata;

`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
    logic         r_misalign;
    logic         w_misalign;

    assign w_misalign     = is_misaligned(redirect_pc);
    assign w_redir_pc     = redirect_pc;
    assign fetch_misalign = r_misalign;
`else
    // Target is forced to word alignment; masking keeps every bit in use.
    assign w_redir_pc = redirect_pc & ~t_pc_addr'(3);
`endif

    // ---- next state ----
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
            if (w_misalign) begin
                w_state_next = HALT;
            end else if (r_state == IDLE) begin
                w_state_next = IDLE;
            end else begin
                w_state_next = RUN;
            end
`else
            // A redirect while idle only moves the PC; it never starts fetching.
            if (r_state == IDLE) begin
                w_state_next = IDLE;
            end else begin
                w_state_next = RUN;
            end
`endif
        end else begin
            case (r_state)
                IDLE:    if (fetch_en)  w_state_next = RUN;
                RUN:     if (!fetch_en) w_state_next = IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---- push / pop control ----
    // The IDLE cycle with fetch_en high is the edge that enters RUN; its fetch
    // is captured too, so the first word reaches the head one cycle after
    // fetching is enabled. HALT never pushes.
    assign w_pop  = ~w_empty & instr_ready & ~redirect_valid;
    assign w_push = fetch_en & ~redirect_valid &
                    ((r_state == RUN) | (r_state == IDLE)) &
                    (~w_full | w_pop);

    // ---- program counter ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redir_pc;
        end else if (w_push) begin
            r_pc <= r_pc + PC_INC;
        end
    end

`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
    // Any redirect rewrites the flag: misaligned sets it, aligned clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= w_misalign;
        end
    end
`endif

    assign imem_addr = r_pc;

    // ---- fetch buffer ----
    assign w_wdata.pc    = r_pc;
    assign w_wdata.instr = imem_rd_data;

    risc_v_mike_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head outputs are forced to zero when empty so stale storage never leaks.
    assign instr_valid = ~w_empty;
    assign instr_data  = w_empty ? '0 : w_rdata.instr;
    assign instr_pc    = w_empty ? '0 : w_rdata.pc;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
module tb_risc_v_mike_fetch_unit;
    import risc_v_mike_pkg::*;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic [31:0] imem_addr,  imem_addr2;
    logic [31:0] imem_rd_data, imem_rd_data2;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr_data, instr_data2;
    logic [31:0] instr_pc, instr_pc2;
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign, fetch_misalign2;
`endif

    int checks;
    int errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00f00093;
            32'h4:   return 32'h00800113;
            32'h8:   return 32'h002081b3;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    assign imem_rd_data  = mem_word(imem_addr);
    assign imem_rd_data2 = mem_word(imem_addr2);

    risc_v_mike_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rd_data   (imem_rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    risc_v_mike_fetch_unit #(.RESET_PC(32'hFFFFFFF8), .FIFO_DEPTH(2)) dut2 (
        .clk            (clk),
        .rst            (rst2),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr2),
        .imem_rd_data   (imem_rd_data2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid2),
        .instr_data     (instr_data2),
        .instr_pc       (instr_pc2),
        .instr_ready    (instr_ready)
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over one edge, release just after it.
    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst2 = 1'b0;
        fetch_en = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", instr_data, 32'h0); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", instr_pc, 32'h0); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, 32'h0); end
        checks++; if (imem_addr2 !== 32'hFFFFFFF8) begin errors++; $display("FAIL reset_imem_addr2 got %h exp %h", imem_addr2, 32'hFFFFFFF8); end
        checks++; if (instr_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %h exp %h", instr_valid2, 1'b0); end
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h exp %h", fetch_misalign, 1'b0); end
`endif
    endtask

    task automatic test_fetch_seq();
        logic [31:0] exp_pc;
        fetch_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            exp_pc = 32'(4 * k);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %h exp %h", k, instr_valid, 1'b1); end
            checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", k, instr_pc, exp_pc); end
            checks++; if (instr_data !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_data[%0d] got %h exp %h", k, instr_data, mem_word(exp_pc)); end
            checks++; if (imem_addr !== exp_pc + 32'h4) begin errors++; $display("FAIL seq_imem_addr[%0d] got %h exp %h", k, imem_addr, exp_pc + 32'h4); end
        end
    endtask

    task automatic test_backpressure();
        fetch_en = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
        end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_imem_frozen got %h exp %h", imem_addr, 32'h8); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc got %h exp %h", instr_pc, 32'h0); end
        checks++; if (instr_data !== 32'h00f00093) begin errors++; $display("FAIL bp_head_data got %h exp %h", instr_data, 32'h00f00093); end
        // Stop fetching and drain: exactly two entries must come out.
        fetch_en = 1'b0; instr_ready = 1'b1;
        step();
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL bp_drain1_pc got %h exp %h", instr_pc, 32'h4); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_drain1_valid got %h exp %h", instr_valid, 1'b1); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drain2_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL bp_empty_data got %h exp %h", instr_data, 32'h0); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_empty_pc got %h exp %h", instr_pc, 32'h0); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_idle_imem got %h exp %h", imem_addr, 32'h8); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_pc;
        fetch_en = 1'b1; instr_ready = 1'b0;
        do_reset();
        step();
        step();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_pc = 32'(4 * (k + 1));
            checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL full_pp_pc[%0d] got %h exp %h", k, instr_pc, exp_pc); end
            // Occupancy 2: fetch address runs two words ahead of the head.
            checks++; if (imem_addr !== exp_pc + 32'h8) begin errors++; $display("FAIL full_pp_occ[%0d] got %h exp %h", k, imem_addr, exp_pc + 32'h8); end
        end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b1; instr_ready = 1'b0;
        do_reset();
        step();
        step();
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL redir_pre_pc got %h exp %h", instr_pc, 32'h0); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_imem got %h exp %h", imem_addr, 32'h40); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_tgt_valid got %h exp %h", instr_valid, 1'b1); end
        checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL redir_tgt_pc got %h exp %h", instr_pc, 32'h40); end
        checks++; if (instr_data !== mem_word(32'h40)) begin errors++; $display("FAIL redir_tgt_data got %h exp %h", instr_data, mem_word(32'h40)); end
    endtask

    task automatic test_misalign();
        fetch_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
`ifdef RISC_V_MIKE_FETCH_MISALIGN_CHK_EN
        checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag_set got %h exp %h", fetch_misalign, 1'b1); end
        step();
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_halt_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (imem_addr !== 32'h42) begin errors++; $display("FAIL mis_halt_imem got %h exp %h", imem_addr, 32'h42); end
        redirect_valid = 1'b1; redirect_pc = 32'h44;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag_clr got %h exp %h", fetch_misalign, 1'b0); end
        step();
        checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL mis_resume_pc got %h exp %h", instr_pc, 32'h44); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mis_resume_valid got %h exp %h", instr_valid, 1'b1); end
`else
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL mis_forced_imem got %h exp %h", imem_addr, 32'h40); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_flush_valid got %h exp %h", instr_valid, 1'b0); end
        step();
        checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL mis_forced_pc got %h exp %h", instr_pc, 32'h40); end
        checks++; if (instr_data !== mem_word(32'h40)) begin errors++; $display("FAIL mis_forced_data got %h exp %h", instr_data, mem_word(32'h40)); end
`endif
    endtask

    task automatic test_idle_redirect();
        fetch_en = 1'b0; instr_ready = 1'b1;
        do_reset();
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %h exp %h", instr_valid, 1'b0); end
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL idle_redir_imem got %h exp %h", imem_addr, 32'h80); end
        step();
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_stays_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL idle_stays_imem got %h exp %h", imem_addr, 32'h80); end
        fetch_en = 1'b1;
        step();
        checks++; if (instr_pc !== 32'h80) begin errors++; $display("FAIL idle_start_pc got %h exp %h", instr_pc, 32'h80); end
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %h exp %h", instr_valid, 1'b1); end
        rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %h exp %h", instr_valid, 1'b0); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_imem got %h exp %h", imem_addr, 32'h0); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL ar_pc got %h exp %h", instr_pc, 32'h0); end
        rst = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFFFFF8; exp_pc[1] = 32'hFFFFFFFC; exp_pc[2] = 32'h0;
        fetch_en = 1'b1; instr_ready = 1'b1;
        rst2 = 1'b0;
        step();
        rst2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (instr_pc2 !== exp_pc[k]) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, instr_pc2, exp_pc[k]); end
            checks++; if (instr_data2 !== mem_word(exp_pc[k])) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", k, instr_data2, mem_word(exp_pc[k])); end
        end
        checks++; if (instr_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %h exp %h", instr_valid2, 1'b1); end
        rst2 = 1'b0;
        #1;
        checks++; if (instr_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_rst_valid got %h exp %h", instr_valid2, 1'b0); end
        checks++; if (imem_addr2 !== 32'hFFFFFFF8) begin errors++; $display("FAIL wrap_rst_imem got %h exp %h", imem_addr2, 32'hFFFFFFF8); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_full_push_pop();
        test_redirect();
        test_misalign();
        test_idle_redirect();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
